// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and data access.
// Data wins ties until IF has waited through STARVE_MAX data grants.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_done,
    output logic [DW-1:0] if_rdata,
    output logic          if_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [3:0]    d_be,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          d_stall,
    output logic          m_req,
    output logic          m_we,
    output logic [3:0]    m_be,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic          m_ack,
    input  logic [DW-1:0] m_rdata,
    output logic [1:0]    owner
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam int             CW         = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0]  STARVE_LIM = CW'(STARVE_MAX);
    localparam logic [1:0]     OWN_NONE   = 2'd0;
    localparam logic [1:0]     OWN_IF     = 2'd1;
    localparam logic [1:0]     OWN_D      = 2'd2;

    state_t        state;
    logic [CW-1:0] starve_cnt;
    logic          grant_d;
    logic          grant_if;

    always_comb begin
        grant_d  = d_req && (!if_req || (starve_cnt < STARVE_LIM));
        grant_if = if_req && !grant_d;
    end

    assign if_stall = if_req & ~if_done;
    assign d_stall  = d_req & ~d_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_be       <= '0;
            m_addr     <= '0;
            m_wdata    <= '0;
            if_done    <= 1'b0;
            d_done     <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            owner      <= OWN_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        m_req   <= 1'b1;
                        m_we    <= d_we;
                        m_be    <= d_we ? d_be : 4'b1111;
                        m_addr  <= {d_addr[AW-1:2], 2'b00};
                        m_wdata <= d_wdata;
                        owner   <= OWN_D;
                        state   <= BUSY;
                        // Only grants that actually make IF wait count toward starvation.
                        if (if_req && (starve_cnt != STARVE_LIM))
                            starve_cnt <= starve_cnt + 1'b1;
                    end else if (grant_if) begin
                        m_req      <= 1'b1;
                        m_we       <= 1'b0;
                        m_be       <= 4'b1111;
                        m_addr     <= {if_addr[AW-1:2], 2'b00};
                        m_wdata    <= '0;
                        owner      <= OWN_IF;
                        state      <= BUSY;
                        starve_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (m_ack) begin
                        m_req <= 1'b0;
                        state <= RESP;
                        if (owner == OWN_IF) begin
                            if_rdata <= m_rdata;
                            if_done  <= 1'b1;
                        end else begin
                            if (!m_we)
                                d_rdata <= m_rdata;
                            d_done <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if_done <= 1'b0;
                    d_done  <= 1'b0;
                    owner   <= OWN_NONE;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected memory transactions are queued
// as requests are raised and checked as the arbiter presents them.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        d_stall;
    logic        m_req;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic [1:0]  owner;

    mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
        .if_rdata(if_rdata), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata), .owner(owner)
    );

    typedef struct {
        logic [1:0]  own;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } txn_t;

    txn_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_if_rdata = '0;
    logic [31:0] exp_d_rdata  = '0;
    int          lat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_if(input logic [31:0] a);
        txn_t t;
        t.own = 2'd1; t.addr = {a[31:2], 2'b00}; t.we = 1'b0; t.be = 4'hF; t.wdata = '0;
        exp_q.push_back(t);
    endtask

    task automatic push_d(input logic we, input logic [3:0] be, input logic [31:0] a,
                          input logic [31:0] wd);
        txn_t t;
        t.own = 2'd2; t.addr = {a[31:2], 2'b00}; t.we = we;
        t.be = we ? be : 4'hF; t.wdata = wd;
        exp_q.push_back(t);
    endtask

    // Called at a negedge; returns at the negedge of the response cycle.
    task automatic serve(input int waits, input logic [31:0] rdata, output int n);
        txn_t e;
        n = 0;
        while (!m_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!m_req) begin
            check("mreq_timeout", 32'd0, 32'd1);
            return;
        end
        if (exp_q.size() == 0) begin
            check("unexpected_txn", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        for (int w = 0; w <= waits; w++) begin
            check("busy_m_req", m_req, 1);
            check("busy_owner", owner, e.own);
            check("busy_m_addr", m_addr, e.addr);
            check("busy_m_we", m_we, e.we);
            check("busy_m_be", m_be, e.be);
            if (e.we) check("busy_m_wdata", m_wdata, e.wdata);
            if (e.own == 2'd1 && if_req) check("busy_if_stall", if_stall, 1);
            if (e.own == 2'd2 && d_req)  check("busy_d_stall", d_stall, 1);
            m_ack   = (w == waits);
            m_rdata = (w == waits) ? rdata : $urandom;
            @(negedge clk);
        end
        m_ack   = 1'b0;
        m_rdata = $urandom;
        if (e.own == 2'd1) exp_if_rdata = rdata;
        else if (!e.we)    exp_d_rdata  = rdata;
        check("resp_if_done", if_done, e.own == 2'd1);
        check("resp_d_done", d_done, e.own == 2'd2);
        check("resp_if_rdata", if_rdata, exp_if_rdata);
        check("resp_d_rdata", d_rdata, exp_d_rdata);
        check("resp_m_req", m_req, 0);
        check("resp_owner", owner, e.own);
    endtask

    initial begin
        rst = 1'b0; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_be = '0;
        d_addr = '0; d_wdata = '0; m_ack = 0; m_rdata = '0;
        #1;
        check("rst_m_req", m_req, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_be", m_be, 0);
        check("rst_owner", owner, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // 1: fetch only, zero-wait memory
        if_req = 1; if_addr = 32'h0000_0040;
        push_if(32'h0000_0040);
        #1 check("t1_stall_c0", if_stall, 1);
        serve(0, 32'h2008_0005, lat);
        check("t1_latency", lat, 1);
        check("t1_stall_c2", if_stall, 0);
        if_req = 0;
        @(negedge clk);

        // 2: simultaneous requests, data first
        if_req = 1; if_addr = 32'h0000_0080;
        d_req = 1; d_we = 0; d_addr = 32'h0000_1000;
        push_d(0, 4'h0, 32'h0000_1000, 32'h0);
        push_if(32'h0000_0080);
        serve(0, 32'h1111_0000, lat);
        d_req = 0;
        serve(1, 32'h2222_0000, lat);
        if_req = 0;
        @(negedge clk);

        // 3: starvation limit, twice to show the counter clears on the IF grant
        if_req = 1; if_addr = 32'h0000_0100;
        d_req = 1; d_we = 0; d_addr = 32'h0000_2004;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) push_d(0, 4'h0, 32'h0000_2004, 32'h0);
            push_if(32'h0000_0100);
        end
        for (int k = 0; k < 10; k++) serve(k % 3, 32'h3000_0000 + k, lat);
        if_req = 0;
        push_d(0, 4'h0, 32'h0000_2004, 32'h0);
        serve(0, 32'h3300_0000, lat);
        d_req = 0;
        @(negedge clk);

        // 4: store after preloading d_rdata
        d_req = 1; d_we = 0; d_addr = 32'h0000_0200;
        push_d(0, 4'h0, 32'h0000_0200, 32'h0);
        serve(0, 32'h0000_1234, lat);
        d_req = 0;
        @(negedge clk);
        d_req = 1; d_we = 1; d_addr = 32'h0000_0103; d_be = 4'b0011; d_wdata = 32'hAABB_CCDD;
        push_d(1, 4'b0011, 32'h0000_0103, 32'hAABB_CCDD);
        serve(0, 32'hDEAD_BEEF, lat);
        check("t4_d_rdata_hold", d_rdata, 32'h0000_1234);
        d_req = 0; d_we = 0;
        @(negedge clk);

        // 5: wait states, then a stray ack while idle
        d_req = 1; d_addr = 32'h0000_0300;
        push_d(0, 4'h0, 32'h0000_0300, 32'h0);
        serve(5, 32'h5555_AAAA, lat);
        d_req = 0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            m_ack = 1; m_rdata = 32'hBAD0_0000 + k;
            @(negedge clk);
            check("t5_stray_if_done", if_done, 0);
            check("t5_stray_d_done", d_done, 0);
            check("t5_stray_m_req", m_req, 0);
            check("t5_stray_d_rdata", d_rdata, exp_d_rdata);
            check("t5_stray_if_rdata", if_rdata, exp_if_rdata);
        end
        m_ack = 0;
        @(negedge clk);

        // 6: reset while busy
        if_req = 1; if_addr = 32'h0000_0400;
        @(negedge clk);
        check("t6_busy_m_req", m_req, 1);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_m_req", m_req, 0);
        check("t6_rst_owner", owner, 0);
        check("t6_rst_if_done", if_done, 0);
        if_req = 0;
        exp_if_rdata = '0; exp_d_rdata = '0;
        @(negedge clk);
        rst = 1'b1; m_ack = 1; m_rdata = 32'hBAD1_0000;
        @(negedge clk);
        m_ack = 0;
        check("t6_late_ack_m_req", m_req, 0);
        check("t6_late_ack_done", if_done, 0);
        check("t6_late_ack_rdata", if_rdata, 0);
        if_req = 1; if_addr = 32'h0000_0444;
        push_if(32'h0000_0444);
        serve(1, 32'h6666_0001, lat);
        if_req = 0;
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
